// File: rtl/axi_lite_wr_sched.sv
// axi_lite_wr_sched: round-robin scheduler sharing one AXI-Lite write channel among N_REQ requesters.
module axi_lite_wr_sched #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PRIO0  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*ADDR_W-1:0]   addr_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  input  logic [N_REQ*DATA_W/8-1:0] strb_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          done_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [ADDR_W-1:0]         aw_addr,
  output logic                      aw_valid,
  input  logic                      aw_ready,
  output logic [DATA_W-1:0]         w_data,
  output logic [DATA_W/8-1:0]       w_strb,
  output logic                      w_valid,
  input  logic                      w_ready,
  input  logic [1:0]                b_resp,
  input  logic                      b_valid,
  output logic                      b_ready
);
  localparam int IW = $clog2(N_REQ);
  localparam int SW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, win_q, win_d, rr_idx, sel;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d, err_q, err_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic prio;
  logic unused_resp;
  assign unused_resp = b_resp[0];
  // Descending scan so the nearest requester after last wins.
  always_comb begin
    rr_idx = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req_i[(int'(last_q) + k) % N_REQ]) rr_idx = IW'((int'(last_q) + k) % N_REQ);
  end
  assign prio = (PRIO0 != 0) && req_i[0];
  assign sel  = prio ? '0 : rr_idx;
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    gnt_d      = '0;
    done_d     = '0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (|req_i) begin
        state_d    = ADDR;
        win_d      = sel;
        last_d     = prio ? last_q : rr_idx;
        aw_addr_d  = addr_i[int'(sel)*ADDR_W +: ADDR_W];
        w_data_d   = data_i[int'(sel)*DATA_W +: DATA_W];
        w_strb_d   = strb_i[int'(sel)*SW +: SW];
        aw_valid_d = 1'b1;
        w_valid_d  = 1'b1;
        gnt_d[sel] = 1'b1;
      end
      ADDR: begin
        aw_valid_d = aw_valid_q && !aw_ready;
        w_valid_d  = w_valid_q && !w_ready;
        if (!aw_valid_d && !w_valid_d) begin
          state_d   = RESP;
          b_ready_d = 1'b1;
        end
      end
      RESP: if (b_valid) begin
        state_d      = IDLE;
        b_ready_d    = 1'b0;
        done_d[win_q] = 1'b1;
        err_d        = b_resp[1];
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= IW'(N_REQ - 1);
      win_q      <= '0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign busy_o   = state_q != IDLE;
  assign aw_addr  = aw_addr_q;
  assign aw_valid = aw_valid_q;
  assign w_data   = w_data_q;
  assign w_strb   = w_strb_q;
  assign w_valid  = w_valid_q;
  assign b_ready  = b_ready_q;
endmodule

// File: doc/axi_lite_wr_sched.md
# axi_lite_wr_sched

Round-robin write scheduler that shares one AXI-Lite master write channel (AW/W/B) among `N_REQ` requesters. It owns the address, data and response handshakes, so it issues exactly one outstanding write at a time. It returns per-requester grant and completion pulses and reports the B-channel error status. It sits between control FSMs (requester 0 is the priority control sequencer) and the AXI-Lite interconnect.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; strobe width is `DATA_W/8`.
- `PRIO0`, 1: 1 gives requester 0 strict priority over round-robin; 0 puts all requesters in pure round-robin.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_i` in N_REQ: per-requester write request level.
- `addr_i` in N_REQ*ADDR_W: packed addresses; requester i occupies slice i.
- `data_i` in N_REQ*DATA_W: packed write data.
- `strb_i` in N_REQ*DATA_W/8: packed byte strobes.
- `gnt_o` out N_REQ: one-hot, 1-cycle pulse; the request is captured.
- `done_o` out N_REQ: one-hot, 1-cycle pulse; the write has completed.
- `err_o` out 1: valid with any `done_o`; equals `b_resp[1]`.
- `busy_o` out 1: high when the scheduler is not in IDLE.
- `aw_addr` out ADDR_W; `aw_valid` out 1; `aw_ready` in 1.
- `w_data` out DATA_W; `w_strb` out DATA_W/8; `w_valid` out 1; `w_ready` in 1.
- `b_resp` in 2; `b_valid` in 1; `b_ready` out 1.

## Operation
- Reset (`rst`=0): every output is 0, state is IDLE, and the round-robin pointer `last` is N_REQ-1, so requester 0 is searched first.
- Request contract:
  - A requester holds `req_i`, address, data and strobe stable until it sees its `gnt_o`.
  - After `gnt_o` it may change them freely.
  - It must not re-request until its `done_o` has pulsed.
  - Any `req_i` still high after `gnt_o` is treated as a new request.
- Arbitration happens only in IDLE:
  - If `PRIO0`=1 and `req_i[0]` is high, requester 0 wins.
  - Otherwise the winner is the first set `req_i` searching `last+1, last+2, …` modulo N_REQ.
  - `last` is updated to the winner. It is not updated when requester 0 wins through priority override.
- States and transitions:
  - IDLE → ADDR when any request is pending. On that edge the scheduler latches the winner's addr/data/strb into `aw_addr`/`w_data`/`w_strb`, sets `aw_valid`=`w_valid`=1, and pulses the winner's `gnt_o`.
  - ADDR: `aw_valid` clears on the edge where `aw_valid&&aw_ready`, and `w_valid` clears on the edge where `w_valid&&w_ready`. The two channels complete independently and in either order.
    - The state moves to RESP on the edge where the last remaining channel completes, including the case where both complete in the same cycle. `b_ready` is set on that same edge.
  - RESP: on `b_valid&&b_ready` the scheduler clears `b_ready`, pulses `done_o[winner]` with `err_o`=`b_resp[1]`, and returns to IDLE.
- `aw_addr`, `w_data` and `w_strb` hold their latched values until the next grant.
- A `b_valid` seen in IDLE or ADDR is ignored because `b_ready`=0. There is no timeout: the scheduler waits indefinitely in ADDR or RESP.
- An asynchronous reset mid-transaction aborts it immediately: all valids and `b_ready` drop to 0, and no `done_o` is issued.

## Timing
- Grant latency is 1 cycle: `req_i` high in IDLE at cycle t gives `gnt_o`, `aw_valid` and `w_valid` high at t+1.
- With `aw_ready`, `w_ready` and `b_valid` held at 1:
  - AW and W handshake at t+1.
  - `b_ready` is high at t+2 and B handshakes at t+2.
  - `done_o` is high at t+3 with the state back in IDLE.
  - The next grant is at t+4, giving a throughput of one write per 3 cycles.
- `done_o` and `gnt_o` for the same requester are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `busy_o` is high from the `gnt_o` cycle through the cycle before `done_o`.

## Test plan
- **Single write:** `req_i`=4'b0010, addr 0x1000_0040, data 0xDEAD_BEEF, strb 4'hF, slave always ready, b_resp=0 -> `gnt_o`[1] at t+1, AW/W carry those values, `done_o`[1] at t+3, `err_o`=0.
- **Skewed channels:** `w_ready` delayed 3 cycles after `aw_ready` -> `aw_valid` drops first, `w_valid` stays high 3 more cycles, `b_ready` rises only after W completes, exactly one `done_o`.
- **Round-robin:** all four `req_i` held high with `PRIO0`=0, each requester re-asserting after its own `done_o` -> grant order 0,1,2,3,0 with no repeats.
- **Priority override:** `PRIO0`=1, requesters 2 and 0 both requesting -> 0 is granted first, then 2; a following request by 3 alongside a re-request by 2 -> 3 is granted.
- **Error response:** b_resp=2'b10 -> `done_o` pulse with `err_o`=1; a later b_resp=2'b00 -> `err_o`=0.
- **Reset mid-transaction:** `rst` asserted low while in RESP -> all outputs 0 asynchronously; after release, a new request is served normally and no stale `done_o` appears.
